// File: rtl/useq_fifo_host.sv
// useq_fifo_host: host-side initiator for the useq mailbox FIFO port.
// Turns an inbound valid/ready byte stream into write_fifo strobes and drains the
// FIFO into an outbound valid/ready stream. Only one strobe is issued at a time, and
// every strobe is followed by enforced idle cycles so the useq CPU keeps running.
// useq has no full flag, so the host tracks write credit in 'occupancy' and resyncs
// it to 0 whenever fifo_empty is seen in IDLE.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high;
// once m_valid is raised, m_data stays stable and m_valid stays high until that edge.
// Optional build macro USEQ_FIFO_HOST_STATS_EN adds the wr_total/rd_total counters;
// without it both ports are tied to 0.
module useq_fifo_host #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [7:0]                  m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        write_fifo,
  output logic [7:0]                  fifo_in,
  output logic                        read_fifo,
  input  logic [7:0]                  fifo_out,
  input  logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] occupancy,
  output logic [15:0]                 wr_total,
  output logic [15:0]                 rd_total
);

  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [OW-1:0] CREDIT_MAX = OW'(FIFO_DEPTH - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gap_cnt_q;
  logic          prio_wr_q, prio_wr_d;
  logic [OW-1:0] occ_q;
  logic [7:0]    fifo_in_q;
  logic [7:0]    m_data_q;
  logic          m_valid_q;
  logic          wr_elig, rd_elig, idle_eval;
  logic          wr_grant, rd_grant;

  // Arbitration: which operation (if any) IDLE starts this cycle.
  always_comb begin
    wr_elig   = s_valid && (occ_q < CREDIT_MAX);
    rd_elig   = !fifo_empty && !m_valid_q;
    idle_eval = (state_q == ST_IDLE) && (gap_cnt_q == '0);
    wr_grant  = 1'b0;
    rd_grant  = 1'b0;
    prio_wr_d = prio_wr_q;
    if (idle_eval) begin
      if (wr_elig && rd_elig) begin
        // Contended: honour the priority bit, then hand priority to the other side.
        wr_grant  = prio_wr_q;
        rd_grant  = !prio_wr_q;
        prio_wr_d = !prio_wr_q;
      end else begin
        wr_grant = wr_elig;
        rd_grant = rd_elig;
      end
    end
  end

  // Next-state logic and strobe decode.
  always_comb begin
    state_d    = state_q;
    s_ready    = wr_grant;
    write_fifo = (state_q == ST_WR);
    read_fifo  = (state_q == ST_RD);
    case (state_q)
      ST_IDLE: begin
        if (wr_grant)      state_d = ST_WR;
        else if (rd_grant) state_d = ST_RD;
      end
      ST_WR:   state_d = ST_GAP;
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = ST_GAP;
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and write/read priority bit (write favoured out of reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prio_wr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
    end
  end

  // Gap counter: loaded on each strobe's follow-up state, counts down through GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt_q <= '0;
    end else if (state_q == ST_WR || state_q == ST_CAP) begin
      gap_cnt_q <= GAP_LOAD;
    end else if (state_q == ST_GAP && gap_cnt_q != '0) begin
      gap_cnt_q <= gap_cnt_q - GW'(1);
    end
  end

  // Push data register: captured on the accepting cycle, driven during WR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_in_q <= 8'h00;
    end else if (wr_grant) begin
      fifo_in_q <= s_data;
    end
  end

  // Outbound holding register: filled in CAP, released on the m handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_q  <= 8'h00;
      m_valid_q <= 1'b0;
    end else if (state_q == ST_CAP) begin
      m_data_q  <= fifo_out;
      m_valid_q <= 1'b1;
    end else if (m_valid_q && m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  // Credit estimate: +1 per write, -1 per captured read, forced to 0 when useq is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else if (state_q == ST_IDLE && fifo_empty) begin
      occ_q <= '0;
    end else if (state_q == ST_WR) begin
      occ_q <= occ_q + OW'(1);
    end else if (state_q == ST_CAP && occ_q != '0) begin
      occ_q <= occ_q - OW'(1);
    end
  end

  assign fifo_in   = fifo_in_q;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign occupancy = occ_q;

`ifdef USEQ_FIFO_HOST_STATS_EN
  logic [15:0] wr_total_q, rd_total_q;

  // Wrap-around transfer counters: one per WR state and one per CAP state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_total_q <= 16'd0;
      rd_total_q <= 16'd0;
    end else begin
      if (state_q == ST_WR)  wr_total_q <= wr_total_q + 16'd1;
      if (state_q == ST_CAP) rd_total_q <= rd_total_q + 16'd1;
    end
  end

  assign wr_total = wr_total_q;
  assign rd_total = rd_total_q;
`else
  assign wr_total = 16'd0;
  assign rd_total = 16'd0;
`endif

endmodule
